// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the 7-segment serial link
package seg7_pkg;

  localparam int NUM_DIGITS_DEF     = 6;
  localparam int BITS_PER_DIGIT_DEF = 8;

  // Frame width in bits for a given digit count and digit width
  function automatic int frame_width(input int num_digits, input int bits_per_digit);
    return num_digits * bits_per_digit;
  endfunction

  localparam int W = frame_width(NUM_DIGITS_DEF, BITS_PER_DIGIT_DEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_OVERRUN
  } rx_state_t;

  // Segment bit order inside one digit: bit 7 = dp, bits 6..0 = g..a
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Digit positions in the frame; digit 5 is sent first and lands at the MSB
  localparam int DIGIT_HOURS_MSB   = 5;
  localparam int DIGIT_HOURS_LSB   = 4;
  localparam int DIGIT_MINUTES_MSB = 3;
  localparam int DIGIT_MINUTES_LSB = 2;
  localparam int DIGIT_SECONDS_MSB = 1;
  localparam int DIGIT_SECONDS_LSB = 0;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with rising-edge detect
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchronizer chain followed by one history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/seg7_serial_receiver.sv
// rtl/seg7_serial_receiver.sv - rebuilds parallel digit patterns from the serial display link
module seg7_serial_receiver #(
  parameter int NUM_DIGITS     = 6,
  parameter int BITS_PER_DIGIT = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_serial_data,
  input  logic                               i_serial_clk,
  input  logic                               i_serial_latch,
  output logic [NUM_DIGITS*BITS_PER_DIGIT-1:0] o_digits,
  output logic                               o_frame_valid,
  output logic                               o_frame_err,
  output logic                               o_busy
);
  import seg7_pkg::*;

  localparam int FW    = frame_width(NUM_DIGITS, BITS_PER_DIGIT);
  localparam int CNT_W = $clog2(FW) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FW);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FW + 1);

  logic data_sync, data_rise;
  logic clk_level, clk_rise;
  logic latch_level, latch_rise;
  logic unused_levels;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk(i_clk), .rst(i_reset), .din(i_serial_data), .level(data_sync), .rise(data_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(i_clk), .rst(i_reset), .din(i_serial_clk), .level(clk_level), .rise(clk_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
    .clk(i_clk), .rst(i_reset), .din(i_serial_latch), .level(latch_level), .rise(latch_rise)
  );

  assign unused_levels = ^{data_rise, clk_level, latch_level};

  rx_state_t         state, state_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [FW-1:0]     shift_reg, shift_n;
  logic [FW-1:0]     digits_n;
  logic              valid_n, err_n, busy_n;
  logic              shift_en;

  // State, counters and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      count         <= '0;
      shift_reg     <= '0;
      o_digits      <= '0;
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      shift_reg     <= shift_n;
      o_digits      <= digits_n;
      o_frame_valid <= valid_n;
      o_frame_err   <= err_n;
      o_busy        <= busy_n;
    end
  end

  // Shift first, then let a latch in the same cycle judge the post-shift count
  always_comb begin
    state_n  = state;
    count_n  = count;
    shift_n  = shift_reg;
    digits_n = o_digits;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    shift_en = clk_rise && (state != ST_OVERRUN);

    if (shift_en) begin
      shift_n = {shift_reg[FW-2:0], data_sync};
      count_n = count + CNT_W'(1);
      state_n = (count_n == CNT_OVER) ? ST_OVERRUN : ST_SHIFT;
    end

    if (latch_rise) begin
      if (count_n == CNT_FULL) begin
        digits_n = shift_n;
        valid_n  = 1'b1;
      end else begin
        err_n = 1'b1;
      end
      count_n = '0;
      state_n = ST_IDLE;
    end

    busy_n = (count_n != '0);
  end

endmodule
